// File: rtl/ssd_scan_controller_if.sv
// Load/busy handshake, live display controls and board-facing display pins
// of the seven-segment scan controller.
interface ssd_scan_controller_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BIN_W      = 16
);
  logic [BIN_W-1:0]      value;
  logic                  load;
  logic                  mode;
  logic                  busy;
  logic                  overflow;
  logic                  blank_lz;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;

  modport master (
    output value, load, mode, blank_lz, blink_mask, dp_mask,
    input  busy, overflow, an, seg, dp
  );

  modport slave (
    input  value, load, mode, blank_lz, blink_mask, dp_mask,
    output busy, overflow, an, seg, dp
  );
endinterface

// File: rtl/ssd_scan_controller.sv
// Multiplexed seven-segment driver: captures a binary value, shows it as hex
// or as decimal (sequential double-dabble), with blanking, blink and dp.
module ssd_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int BIN_W        = 16,
  parameter int SCAN_CYCLES  = 262144,
  parameter int BLINK_CYCLES = 25000000
) (
  input logic                  clk,
  input logic                  reset,
  ssd_scan_controller_if.slave bus
);
  localparam int DW    = 4 * NUM_DIGITS;
  localparam int EXT_W = (BIN_W > DW) ? BIN_W : DW;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int SC_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int BL_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [0:0] {S_IDLE, S_CONV} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     digit_reg, bcd_q, bcd_adj, bcd_next;
  logic [BIN_W-1:0]  shift_q;
  logic [CNT_W-1:0]  step_cnt;
  logic [EXT_W-1:0]  value_ext;
  logic              ovf_acc, overflow_q, accept, last_step, shout;
  logic [SC_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic [BL_W-1:0]   blink_cnt;
  logic              blink_phase;
  logic [3:0]        cur_digit;
  logic              zero_above, lz_hit, blanked;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]        seg_d;
  logic              dp_d;

  function automatic logic [DW-1:0] dabble_adj(input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b0000001;  4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;  4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;  4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;  4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;  4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;  default: glyph = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    value_ext = EXT_W'(bus.value);
    accept    = bus.load && (state_q == S_IDLE);
    last_step = (step_cnt == CNT_W'(BIN_W - 1));
    bcd_adj   = dabble_adj(bcd_q);
    shout     = bcd_adj[DW-1];
    bcd_next  = {bcd_adj[DW-2:0], shift_q[BIN_W-1]};
    state_d   = state_q;
    case (state_q)
      S_IDLE:  if (accept && bus.mode) state_d = S_CONV;
      S_CONV:  if (last_step) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture / conversion control; digit_reg only changes atomically.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      digit_reg  <= '0;
      overflow_q <= 1'b0;
      step_cnt   <= '0;
      ovf_acc    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && !bus.mode) begin
        digit_reg  <= value_ext[DW-1:0];
        overflow_q <= ((value_ext >> DW) != '0);
      end
      if (accept && bus.mode) begin
        step_cnt <= '0;
        ovf_acc  <= 1'b0;
      end
      if (state_q == S_CONV) begin
        step_cnt <= step_cnt + 1'b1;
        ovf_acc  <= ovf_acc | shout;
        if (last_step) begin
          digit_reg  <= bcd_next;
          overflow_q <= ovf_acc | shout;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q <= bus.value;
      bcd_q   <= '0;
    end else if (state_q == S_CONV) begin
      shift_q <= shift_q << 1;
      bcd_q   <= bcd_next;
    end
  end

  // Digit scan and blink timebases.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt    <= '0;
      scan_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (scan_cnt == SC_W'(SCAN_CYCLES - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    cur_digit  = digit_reg[{scan_idx, 2'b00} +: 4];
    zero_above = 1'b1;
    lz_hit     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (digit_reg[4*i +: 4] == 4'h0);
      if (i == int'(scan_idx)) lz_hit = zero_above;
    end
    blanked = ((scan_idx != '0) && bus.blank_lz && lz_hit) ||
              (blink_phase && bus.blink_mask[scan_idx]);
    an_d           = '1;
    an_d[scan_idx] = blanked;
    seg_d          = blanked ? 7'h7F : glyph(cur_digit);
    dp_d           = blanked | ~bus.dp_mask[scan_idx];
  end

  assign bus.busy     = (state_q == S_CONV);
  assign bus.overflow = overflow_q;
  assign bus.an       = an_d;
  assign bus.seg      = seg_d;
  assign bus.dp       = dp_d;
endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboard bench for ssd_scan_controller: stimulus queues cycle-stamped
// expected display/status words, a negedge monitor pops and compares them.
module tb_ssd_scan_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ssd_scan_controller_if #(.NUM_DIGITS(4), .BIN_W(16)) bus ();

  ssd_scan_controller #(
    .NUM_DIGITS(4), .BIN_W(16), .SCAN_CYCLES(4), .BLINK_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010,
                         G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100,
                         G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000,
                         G9 = 7'b0000100, GA = 7'b0001000, GB = 7'b1100000,
                         GC = 7'b0110001, GD = 7'b1000010, GE = 7'b0110000,
                         GF = 7'b0111000;

  typedef struct {
    int          cyc;
    string       nm;
    logic [13:0] v;   // {an, seg, dp, busy, overflow}
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   rbase = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [13:0] act;
    exp_t        e;
    act = {bus.an, bus.seg, bus.dp, bus.busy, bus.overflow};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_total++;
      if (e.cyc == cyc && act == e.v) n_pass++;
      else
        $display("FAIL %s cyc=%0d/%0d got an=%b seg=%b dp=%b busy=%b ovf=%b expected an=%b seg=%b dp=%b busy=%b ovf=%b",
                 e.nm, cyc, e.cyc, act[13:10], act[9:3], act[2], act[1], act[0],
                 e.v[13:10], e.v[9:3], e.v[2], e.v[1], e.v[0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [13:0] v);
    exp_t e;
    e.cyc = cyc;
    e.nm  = nm;
    e.v   = v;
    sb.push_back(e);
  endtask

  // g = {glyph3, glyph2, glyph1, glyph0}; lzb = digits blanked as leading zeros
  task automatic frames(input int n, input string nm, input logic [27:0] g,
                        input logic [3:0] lzb, input logic [3:0] blm,
                        input logic [3:0] dpm, input logic be, input logic oe);
    int         s, ph;
    logic       bl;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    for (int k = 0; k < n; k++) begin
      s     = ((cyc - rbase) / 4) % 4;
      ph    = ((cyc - rbase) / 16) % 2;
      bl    = lzb[s] | ((ph == 1) & blm[s]);
      an_e  = 4'hF;
      if (!bl) an_e[s] = 1'b0;
      seg_e = bl ? 7'h7F : g[7*s +: 7];
      dp_e  = bl | ~dpm[s];
      push(nm, {an_e, seg_e, dp_e, be, oe});
      tick(1);
    end
  endtask

  task automatic do_load(input logic m, input logic [15:0] v);
    bus.mode  = m;
    bus.value = v;
    bus.load  = 1'b1;
    tick(1);
    bus.load  = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.value      = '0;
    bus.load       = 1'b0;
    bus.mode       = 1'b0;
    bus.blank_lz   = 1'b0;
    bus.blink_mask = '0;
    bus.dp_mask    = '0;

    tick(2);
    push("reset_hold", {4'b1110, G0, 1'b1, 1'b0, 1'b0});
    reset = 1'b0;
    rbase = cyc;
    frames(20, "after_reset", {G0, G0, G0, G0}, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    do_load(1'b0, 16'h1A3F);
    frames(20, "hex_1a3f", {G1, GA, G3, GF}, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    do_load(1'b0, 16'hBCDE);
    frames(16, "hex_bcde", {GB, GC, GD, GE}, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    do_load(1'b0, 16'h6890);
    frames(16, "hex_6890", {G6, G8, G9, G0}, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    do_load(1'b1, 16'd1234);
    frames(5, "conv_1234_old", {G6, G8, G9, G0}, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0);
    bus.mode  = 1'b0;
    bus.value = 16'h0005;
    bus.load  = 1'b1;
    frames(1, "load_while_busy", {G6, G8, G9, G0}, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0);
    bus.load  = 1'b0;
    frames(10, "conv_1234_old", {G6, G8, G9, G0}, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0);
    frames(16, "dec_1234", {G1, G2, G3, G4}, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    do_load(1'b1, 16'd12345);
    frames(16, "conv_12345_old", {G1, G2, G3, G4}, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0);
    frames(16, "dec_12345_ovf", {G2, G3, G4, G5}, 4'b0, 4'b0, 4'b0, 1'b0, 1'b1);

    bus.blank_lz = 1'b1;
    do_load(1'b1, 16'd7);
    frames(16, "conv_7_old", {G2, G3, G4, G5}, 4'b0, 4'b0, 4'b0, 1'b1, 1'b1);
    frames(16, "dec_7_lz", {G0, G0, G0, G7}, 4'b1110, 4'b0, 4'b0, 1'b0, 1'b0);

    bus.blank_lz   = 1'b0;
    bus.blink_mask = 4'b0001;
    bus.dp_mask    = 4'b0010;
    frames(40, "blink_dp", {G0, G0, G0, G7}, 4'b0, 4'b0001, 4'b0010, 1'b0, 1'b0);

    bus.blink_mask = 4'b0;
    bus.dp_mask    = 4'b0;
    do_load(1'b1, 16'd1234);
    frames(5, "conv_abort_old", {G0, G0, G0, G7}, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0);
    reset = 1'b1;
    tick(1);
    push("reset_mid_conv", {4'b1110, G0, 1'b1, 1'b0, 1'b0});
    reset = 1'b0;
    rbase = cyc;
    frames(24, "after_abort", {G0, G0, G0, G0}, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    tick(2);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
